// File: rtl/video_timing_gen_if.sv
// rtl/video_timing_gen_if.sv - run request and timing/address outputs between generator and sink
// Optional: VIDEO_TIMING_GEN_FRAME_COUNT_EN adds frame_cnt to the bundle.
interface video_timing_gen_if #(
  parameter int CNT_W  = 13,
  parameter int ADDR_W = 17
);
  logic              en;
  logic              hsync;
  logic              vsync;
  logic              vde;
  logic              sof;
  logic              eof;
  logic [CNT_W-1:0]  pixel_x;
  logic [CNT_W-1:0]  pixel_y;
  logic [ADDR_W-1:0] fbuf_addr;
  logic              running;
`ifdef VIDEO_TIMING_GEN_FRAME_COUNT_EN
  logic [15:0]       frame_cnt;
`endif

  modport master (
    input  en,
    output hsync, vsync, vde, sof, eof, pixel_x, pixel_y, fbuf_addr, running
`ifdef VIDEO_TIMING_GEN_FRAME_COUNT_EN
    , output frame_cnt
`endif
  );

  modport slave (
    output en,
    input  hsync, vsync, vde, sof, eof, pixel_x, pixel_y, fbuf_addr, running
`ifdef VIDEO_TIMING_GEN_FRAME_COUNT_EN
    , input frame_cnt
`endif
  );
endinterface

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator with syncs, active video and upscaled framebuffer address
// Optional: VIDEO_TIMING_GEN_FRAME_COUNT_EN adds a 16-bit wrapping frame counter output.
module video_timing_gen #(
  parameter int H_ACTIVE   = 1920,
  parameter int H_FP       = 88,
  parameter int H_SYNC     = 44,
  parameter int H_BP       = 148,
  parameter int V_ACTIVE   = 1080,
  parameter int V_FP       = 4,
  parameter int V_SYNC     = 5,
  parameter int V_BP       = 36,
  parameter bit HSYNC_POL  = 1'b1,
  parameter bit VSYNC_POL  = 1'b1,
  parameter int SCALE_LOG2 = 3,
  parameter int ADDR_W     = 17,
  parameter int CNT_W      = 13
) (
  input  logic               clk,
  input  logic               rst_n,
  video_timing_gen_if.master vif
);
  localparam int HT   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FB_W = H_ACTIVE >> SCALE_LOG2;

  if ((H_ACTIVE % (1 << SCALE_LOG2)) != 0) begin : g_err_scale
    $error("H_ACTIVE is not a multiple of 2**SCALE_LOG2");
  end
  if (longint'(HT) > (longint'(1) << CNT_W) || longint'(VT) > (longint'(1) << CNT_W)) begin : g_err_cnt
    $error("HT or VT does not fit in CNT_W");
  end
  if (longint'(FB_W) * longint'(V_ACTIVE >> SCALE_LOG2) > (longint'(1) << ADDR_W)) begin : g_err_addr
    $error("framebuffer does not fit in ADDR_W");
  end

  // Sync windows use one extra bit so an end bound equal to 2**CNT_W stays representable.
  localparam logic [CNT_W-1:0]  H_ACT_C   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0]  H_LAST_C  = CNT_W'(HT - 1);
  localparam logic [CNT_W:0]    HS_BEG_C  = (CNT_W + 1)'(H_ACTIVE + H_FP);
  localparam logic [CNT_W:0]    HS_END_C  = (CNT_W + 1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0]  V_ACT_C   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0]  V_LAST_C  = CNT_W'(VT - 1);
  localparam logic [CNT_W:0]    VS_BEG_C  = (CNT_W + 1)'(V_ACTIVE + V_FP);
  localparam logic [CNT_W:0]    VS_END_C  = (CNT_W + 1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0]  SUB_MSK_C = CNT_W'((1 << SCALE_LOG2) - 1);
  localparam logic [ADDR_W-1:0] FB_W_C    = ADDR_W'(FB_W);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  typedef struct packed {
    logic              vde;
    logic              sof;
    logic              eof;
    logic              hsync;
    logic              vsync;
    logic              running;
    logic [CNT_W-1:0]  x;
    logic [CNT_W-1:0]  y;
    logic [ADDR_W-1:0] addr;
  } stage_t;

  localparam stage_t STAGE_IDLE = '{vde: 1'b0, sof: 1'b0, eof: 1'b0,
                                    hsync: ~HSYNC_POL, vsync: ~VSYNC_POL, running: 1'b0,
                                    x: '0, y: '0, addr: '0};

  logic [1:0]        state_d, state_q;
  logic [CNT_W-1:0]  h_d, h_q, v_d, v_q;
  logic [ADDR_W-1:0] base_d, base_q;
  logic              last_h, last_f;
  stage_t            s1_d, s1_q, s2_d, s2_q;

  // Run/stop control and raster counters; base_q tracks (v>>SCALE_LOG2)*FB_W without a multiplier.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    base_d  = base_q;
    last_h  = (h_q == H_LAST_C);
    last_f  = last_h && (v_q == V_LAST_C);
    case (state_q)
      ST_IDLE: if (vif.en) state_d = ST_RUN;
      ST_RUN:  if (!vif.en) state_d = ST_STOP;
      ST_STOP: begin
        if (vif.en) state_d = ST_RUN;
        else if (last_f) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_q == ST_IDLE) begin
      h_d    = '0;
      v_d    = '0;
      base_d = '0;
    end else if (last_h) begin
      h_d = '0;
      if (v_q == V_LAST_C) begin
        v_d    = '0;
        base_d = '0;
      end else begin
        v_d = v_q + 1'b1;
        if (((v_q + 1'b1) & SUB_MSK_C) == '0) base_d = base_q + FB_W_C;
      end
    end else begin
      h_d = h_q + 1'b1;
    end
  end

  // Decode the current counter position into raw timing and address (first pipeline stage).
  always_comb begin
    s1_d = STAGE_IDLE;
    if (state_q != ST_IDLE) begin
      s1_d.running = 1'b1;
      s1_d.vde     = (h_q < H_ACT_C) && (v_q < V_ACT_C);
      s1_d.sof     = (h_q == '0) && (v_q == '0);
      s1_d.eof     = (v_q >= V_ACT_C);
      if ({1'b0, h_q} >= HS_BEG_C && {1'b0, h_q} < HS_END_C) s1_d.hsync = HSYNC_POL;
      if ({1'b0, v_q} >= VS_BEG_C && {1'b0, v_q} < VS_END_C) s1_d.vsync = VSYNC_POL;
      if (s1_d.vde) begin
        s1_d.x    = h_q;
        s1_d.y    = v_q;
        s1_d.addr = base_q + ADDR_W'(h_q >> SCALE_LOG2);
      end
    end
  end

  // Output stage simply re-times the decoded bundle so every output lands on the same edge.
  always_comb s2_d = s1_q;

  // State, counters and both pipeline stages; reset drops everything to idle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      h_q     <= '0;
      v_q     <= '0;
      base_q  <= '0;
      s1_q    <= STAGE_IDLE;
      s2_q    <= STAGE_IDLE;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      base_q  <= base_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
    end
  end

  assign vif.vde       = s2_q.vde;
  assign vif.sof       = s2_q.sof;
  assign vif.eof       = s2_q.eof;
  assign vif.hsync     = s2_q.hsync;
  assign vif.vsync     = s2_q.vsync;
  assign vif.running   = s2_q.running;
  assign vif.pixel_x   = s2_q.x;
  assign vif.pixel_y   = s2_q.y;
  assign vif.fbuf_addr = s2_q.addr;

`ifdef VIDEO_TIMING_GEN_FRAME_COUNT_EN
  logic [15:0] frame_cnt_d, frame_cnt_q;

  // Count frames on the edge that presents sof, so the new value shows alongside it.
  always_comb frame_cnt_d = s1_q.sof ? frame_cnt_q + 16'd1 : frame_cnt_q;

  // Frame counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cnt_q <= 16'd0;
    else        frame_cnt_q <= frame_cnt_d;
  end

  assign vif.frame_cnt = frame_cnt_q;
`endif
endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - directed self-checking bench for video_timing_gen on a 24x12 raster
module tb_video_timing_gen;
  localparam int CW = 13;
  localparam int AW = 17;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  video_timing_gen_if #(.CNT_W(CW), .ADDR_W(AW)) vif ();

  video_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0),
    .SCALE_LOG2(2), .ADDR_W(AW), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .vif(vif.master)
  );

  typedef struct {
    int k;
    int vde, sof, eof, hs, vs;
    int x, y, addr;
  } vec_t;

  vec_t tbl[$];
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // hsync active-high (inactive 0), vsync active-low (inactive 1)
  task automatic idle_chk(input string name);
    chk({name, "_flags"}, longint'({vif.vde, vif.sof, vif.eof, vif.hsync, vif.vsync, vif.running}), 2);
    chk({name, "_x"}, longint'(vif.pixel_x), 0);
    chk({name, "_y"}, longint'(vif.pixel_y), 0);
    chk({name, "_addr"}, longint'(vif.fbuf_addr), 0);
  endtask

  initial begin
    int ti, k, vde_n, hs_n, vs_n, vs_runs, eof_n, sof_bad, sof_extra, run_late, run_drop, sof_k, got;
    logic vs_prev;

    //            k  vde sof eof hs vs  x  y addr
    tbl.push_back('{  0, 1, 1, 0, 0, 1,  0, 0, 0});
    tbl.push_back('{  1, 1, 0, 0, 0, 1,  1, 0, 0});
    tbl.push_back('{ 15, 1, 0, 0, 0, 1, 15, 0, 3});
    tbl.push_back('{ 16, 0, 0, 0, 0, 1,  0, 0, 0});
    tbl.push_back('{ 17, 0, 0, 0, 0, 1,  0, 0, 0});
    tbl.push_back('{ 18, 0, 0, 0, 1, 1,  0, 0, 0});
    tbl.push_back('{ 20, 0, 0, 0, 1, 1,  0, 0, 0});
    tbl.push_back('{ 21, 0, 0, 0, 0, 1,  0, 0, 0});
    tbl.push_back('{ 54, 1, 0, 0, 0, 1,  6, 2, 1});
    tbl.push_back('{100, 1, 0, 0, 0, 1,  4, 4, 5});
    tbl.push_back('{129, 1, 0, 0, 0, 1,  9, 5, 6});
    tbl.push_back('{149, 1, 0, 0, 0, 1,  5, 6, 5});
    tbl.push_back('{183, 1, 0, 0, 0, 1, 15, 7, 7});
    tbl.push_back('{184, 0, 0, 0, 0, 1,  0, 0, 0});
    tbl.push_back('{192, 0, 0, 1, 0, 1,  0, 0, 0});
    tbl.push_back('{216, 0, 0, 1, 0, 0,  0, 0, 0});
    tbl.push_back('{258, 0, 0, 1, 1, 0,  0, 0, 0});
    tbl.push_back('{263, 0, 0, 1, 0, 0,  0, 0, 0});
    tbl.push_back('{269, 0, 0, 1, 0, 1,  0, 0, 0});
    tbl.push_back('{288, 1, 1, 0, 0, 1,  0, 0, 0});

    // reset held, then 100 idle clocks with en=0
    vif.en = 1'b0;
    repeat (3) @(negedge clk);
    idle_chk("reset_held");
`ifdef VIDEO_TIMING_GEN_FRAME_COUNT_EN
    chk("fcnt_reset", longint'(vif.frame_cnt), 0);
`endif
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      idle_chk("idle_en0");
    end

    // start latency: pixel (0,0) two clocks after the edge that samples en=1
    vif.en = 1'b1;
    @(negedge clk);
    chk("lat_e0_sof", longint'(vif.sof), 0);
    chk("lat_e0_run", longint'(vif.running), 0);
    @(negedge clk);
    chk("lat_e1_sof", longint'(vif.sof), 0);
    chk("lat_e1_vde", longint'(vif.vde), 0);
    @(negedge clk);
    chk("lat_e2_sof", longint'(vif.sof), 1);
    chk("lat_e2_run", longint'(vif.running), 1);
`ifdef VIDEO_TIMING_GEN_FRAME_COUNT_EN
    chk("fcnt_first_sof", longint'(vif.frame_cnt), 1);
`endif

    // table vectors over frame 0, statistics over frame 1
    ti = 0; vde_n = 0; hs_n = 0; vs_n = 0; vs_runs = 0; eof_n = 0; sof_bad = 0;
    vs_prev = 1'b1;
    for (k = 0; k < 576; k++) begin
      if (k > 0) @(negedge clk);
      if (ti < tbl.size() && tbl[ti].k == k) begin
        chk($sformatf("vde@%0d", k), longint'(vif.vde), tbl[ti].vde);
        chk($sformatf("sof@%0d", k), longint'(vif.sof), tbl[ti].sof);
        chk($sformatf("eof@%0d", k), longint'(vif.eof), tbl[ti].eof);
        chk($sformatf("hsync@%0d", k), longint'(vif.hsync), tbl[ti].hs);
        chk($sformatf("vsync@%0d", k), longint'(vif.vsync), tbl[ti].vs);
        chk($sformatf("px@%0d", k), longint'(vif.pixel_x), tbl[ti].x);
        chk($sformatf("py@%0d", k), longint'(vif.pixel_y), tbl[ti].y);
        chk($sformatf("addr@%0d", k), longint'(vif.fbuf_addr), tbl[ti].addr);
        ti++;
      end
      if (vif.sof != ((k % 288) == 0)) sof_bad++;
      if (k >= 288) begin
        if (vif.vde) vde_n++;
        if (vif.hsync) hs_n++;
        if (vif.eof) eof_n++;
        if (!vif.vsync) vs_n++;
        if (!vif.vsync && vs_prev) vs_runs++;
        vs_prev = vif.vsync;
      end
    end
    chk("tbl_consumed", ti, tbl.size());
    chk("sof_period_errs", sof_bad, 0);
    chk("vde_per_frame", vde_n, 128);
    chk("hsync_per_frame", hs_n, 36);
    chk("vsync_per_frame", vs_n, 48);
    chk("vsync_runs", vs_runs, 1);
    chk("eof_per_frame", eof_n, 96);
`ifdef VIDEO_TIMING_GEN_FRAME_COUNT_EN
    chk("fcnt_second_sof", longint'(vif.frame_cnt), 2);
`endif

    // drop en at pixel (3,2) of frame 2: frame completes, then idle
    vde_n = 0; sof_extra = 0; run_late = 0;
    for (k = 576; k <= 900; k++) begin
      @(negedge clk);
      if (k <= 863 && vif.vde) vde_n++;
      if (k > 576 && vif.sof) sof_extra++;
      if (k > 864 && vif.running) run_late++;
      if (k == 576) chk("stop_frame_sof", longint'(vif.sof), 1);
      if (k == 863) chk("stop_run_last", longint'(vif.running), 1);
      if (k == 864) chk("stop_run_fall", longint'(vif.running), 0);
      if (k == 627) begin
        chk("stop_px", longint'(vif.pixel_x), 3);
        chk("stop_py", longint'(vif.pixel_y), 2);
        vif.en = 1'b0;
      end
    end
    chk("stop_frame_vde", vde_n, 128);
    chk("stop_no_sof", sof_extra, 0);
    chk("stop_idle_running", run_late, 0);

    // restart, then drop and re-raise en inside the frame
    vif.en = 1'b1;
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      @(negedge clk);
      if (vif.sof) got = 1;
    end
    chk("restart_sof_seen", got, 1);
    sof_k = -1; run_drop = 0;
    for (k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (vif.sof && sof_k < 0) sof_k = k;
      if (!vif.running) run_drop++;
      if (k == 50) vif.en = 1'b0;
      if (k == 100) vif.en = 1'b1;
    end
    chk("reraise_sof_interval", sof_k, 288);
    chk("reraise_running_drop", run_drop, 0);

    // asynchronous reset between edges, mid-active at pixel (12,0)
    chk("pre_reset_vde", longint'(vif.vde), 1);
    #2;
    rst_n = 1'b0;
    vif.en = 1'b0;
    #1;
    idle_chk("async_rst");
`ifdef VIDEO_TIMING_GEN_FRAME_COUNT_EN
    chk("fcnt_async_rst", longint'(vif.frame_cnt), 0);
`endif
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      idle_chk("post_rst");
    end
    vif.en = 1'b1;
    @(negedge clk);
    chk("rst_lat_e0_sof", longint'(vif.sof), 0);
    @(negedge clk);
    chk("rst_lat_e1_sof", longint'(vif.sof), 0);
    @(negedge clk);
    chk("rst_lat_e2_sof", longint'(vif.sof), 1);
    chk("rst_lat_e2_addr", longint'(vif.fbuf_addr), 0);
    chk("rst_lat_e2_run", longint'(vif.running), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
REQ-002 H_ACTIVE, 1920, active pixels per line; H_FP, 88; H_SYNC, 44; H_BP, 148 (horizontal porch and sync widths in clocks).
REQ-003 V_ACTIVE, 1080, active lines; V_FP, 4; V_SYNC, 5; V_BP, 36 (vertical porch and sync widths in lines).
REQ-004 HSYNC_POL, 1 and VSYNC_POL, 1 set sync polarity (1 = active-high); SCALE_LOG2, 3 is the framebuffer upscale exponent; ADDR_W, 17 is the address width; CNT_W, 13 is the counter width.
REQ-005 The design SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-006 Ports SHALL be, one per line as name, direction, width, meaning:
REQ-007 clk  in  1  pixel clock.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 en  in  1  run request.
REQ-010 hsync, vsync  out  1  sync outputs at parameter polarity.
REQ-011 vde  out  1  active video; sof  out  1  one-cycle pulse at pixel (0,0); eof  out  1  high when the line count is at or above V_ACTIVE.
REQ-012 pixel_x, pixel_y  out  CNT_W  active coordinates, 0 outside active video; fbuf_addr  out  ADDR_W  framebuffer word address, 0 outside active video; running  out  1  generator not idle.

Function
REQ-013 Line total HT SHALL be H_ACTIVE+H_FP+H_SYNC+H_BP; frame total VT SHALL be V_ACTIVE+V_FP+V_SYNC+V_BP; counters h, v SHALL count 0..HT-1 and 0..VT-1; v SHALL advance when h wraps.
REQ-014 The FSM SHALL have states IDLE, RUN and STOPPING; in IDLE, h and v SHALL be held at 0.
REQ-015 IDLE->RUN SHALL occur on en=1, with counting starting from (0,0).
REQ-016 RUN->STOPPING SHALL occur on en=0, and STOPPING->RUN on en=1, with no disturbance to the counters.
REQ-017 STOPPING->IDLE SHALL occur at h=HT-1, v=VT-1; a partial frame SHALL never be emitted.
REQ-018 All outputs SHALL be registered and mutually aligned; the first vde/sof for pixel (0,0) SHALL appear 2 clocks after the edge that samples en=1 in IDLE.
REQ-019 vde SHALL equal (h<H_ACTIVE && v<V_ACTIVE) while not IDLE; in IDLE, vde, sof and eof SHALL be 0 and syncs SHALL be inactive.
REQ-020 hsync SHALL be active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync SHALL be active for whole lines v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
REQ-021 fbuf_addr SHALL equal (pixel_y>>SCALE_LOG2)*FB_W + (pixel_x>>SCALE_LOG2), where FB_W=H_ACTIVE>>SCALE_LOG2.
REQ-022 fbuf_addr SHALL be computed incrementally (line-base accumulator plus column counter) with no multiplier.
REQ-023 Address arithmetic SHALL be truncated to ADDR_W.
REQ-024 Elaboration SHALL fail if H_ACTIVE is not divisible by 2^SCALE_LOG2, if HT or VT exceed 2^CNT_W, or if FB_W*(V_ACTIVE>>SCALE_LOG2) exceeds 2^ADDR_W.
REQ-025 running SHALL be 1 in RUN and STOPPING, and SHALL fall on the clock after the last cycle of the frame.

Reset
REQ-026 When rst_n=0, outputs SHALL change immediately without a clock: state IDLE, h=v=0, vde=sof=eof=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, pixel_x=pixel_y=0, fbuf_addr=0, running=0.
REQ-027 Reset mid-frame SHALL abort the frame; after release, the FSM SHALL resume only via en as from IDLE.

Configuration
REQ-028 Macro VIDEO_TIMING_GEN_FRAME_COUNT_EN, when defined, SHALL add output frame_cnt[15:0], reset to 0, incremented in the cycle sof is asserted and wrapping 0xFFFF->0.
REQ-029 Without VIDEO_TIMING_GEN_FRAME_COUNT_EN, the frame_cnt port and its logic SHALL be absent.

Verification (H_ACTIVE=16,H_FP=2,H_SYNC=3,H_BP=3 -> HT=24; V_ACTIVE=8,V_FP=1,V_SYNC=2,V_BP=1 -> VT=12; SCALE_LOG2=2 -> FB_W=4)
REQ-030 Reset with en=0 for 100 clocks -> vde=0, sof=0, hsync=vsync=inactive, fbuf_addr=0, running=0 throughout.
REQ-031 en=1 continuously -> sof every 288 clocks, 128 vde cycles per frame, hsync active 3 of every 24 clocks, vsync active 48 consecutive clocks per frame.
REQ-032 Address check -> pixel (0,0) gives 0, (5,6) gives 5, (4,4) gives 5, (15,7) gives 7; fbuf_addr=0 during blanking.
REQ-033 en dropped at pixel (3,2) -> frame completes, running falls after the 288th cycle with no further sof; en re-raised during STOPPING -> next sof exactly 288 clocks after the previous one.
REQ-034 rst_n pulsed low between clock edges mid-active -> all outputs at reset values before the next edge; a frame restarts only after en=1.
REQ-035 With VIDEO_TIMING_GEN_FRAME_COUNT_EN defined, frame_cnt preloaded via 65535 frames -> reads 0xFFFF, then 0x0000 in the cycle of the next sof.
